// File: rtl/mul_add_int_if.sv
// Handshake and operand bus shared by mul_add_int and its sequencer.
// It uses the same start/busy/valid protocol as div_int.
interface mul_add_int_if #(parameter int WIDTH = 4);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [WIDTH-1:0]       c;
    logic                   busy;
    logic                   valid;
    logic                   ovf;
    logic [2*WIDTH-1:0]     p;

    modport master (output start, a, b, c, input busy, valid, ovf, p);
    modport slave  (input start, a, b, c, output busy, valid, ovf, p);
endinterface

// File: rtl/mul_add_int.sv
// Sequential unsigned multiply-add p = a*b + c (radix-2 shift-add, WIDTH cycles).
// Feeding it quotient, divisor and remainder rebuilds a div_int dividend.
module mul_add_int #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_add_int_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic                 busy_r;
    logic                 valid_r;
    logic                 ovf_r;
    logic [2*WIDTH-1:0]   p_r;
    logic [2*WIDTH-1:0]   sum;

    // The accumulator cannot wrap: the largest result is 2^(2W) - 2^W.
    always_comb begin
        sum = acc;
        if (mplr[0]) begin
            sum = acc + mcand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            count   <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
            p_r     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        mcand   <= {{WIDTH{1'b0}}, bus.a};
                        mplr    <= bus.b;
                        acc     <= {{WIDTH{1'b0}}, bus.c};
                        count   <= '0;
                        busy_r  <= 1'b1;
                        valid_r <= 1'b0;
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc   <= sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + CW'(1);
                    // Fixed latency: no early exit even when the multiplier runs out of ones.
                    if (count == LAST) begin
                        p_r     <= sum;
                        ovf_r   <= |sum[2*WIDTH-1:WIDTH];
                        busy_r  <= 1'b0;
                        valid_r <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;
    assign bus.ovf   = ovf_r;
    assign bus.p     = p_r;

endmodule

// File: tb/tb_mul_add_int.sv
// Scoreboard bench for mul_add_int: a driver predicts accepted operations from
// a cycle-level model, and a monitor checks each result as valid rises.
module tb_mul_add_int;

    localparam int WIDTH = 4;

    typedef struct {
        logic [63:0] p;
        logic        ovf;
        int          edgeNo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nextFree = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    mul_add_int_if #(.WIDTH(WIDTH)) bus ();

    mul_add_int #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sets inputs for the next rising edge and predicts whether it is accepted.
    task automatic issue(input bit s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] c);
        longint unsigned full;
        exp_t e;
        bus.start = s;
        bus.a = a;
        bus.b = b;
        bus.c = c;
        if (s && rst_n && (cyc + 1) >= nextFree) begin
            full = longint'(a) * longint'(b) + longint'(c);
            e.p = full;
            e.ovf = (full >> WIDTH) != 0;
            e.edgeNo = cyc + 1;
            sb.push_back(e);
            nextFree = cyc + 1 + WIDTH + 1;
        end
    endtask

    task automatic driveCycle(input bit s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c);
        @(negedge clk);
        issue(s, a, b, c);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c, input int idle);
        driveCycle(1'b1, a, b, c);
        for (int i = 0; i < idle; i++) begin
            driveCycle(1'b0, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},  64'(bus.busy),  64'd0);
        checkOutput({tag, "_valid"}, 64'(bus.valid), 64'd0);
        checkOutput({tag, "_ovf"},   64'(bus.ovf),   64'd0);
        checkOutput({tag, "_p"},     64'(bus.p),     64'd0);
    endtask

    // Reset lands mid-cycle; outputs must clear before any further clock edge.
    task automatic doReset(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] c);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkResetOutputs("async_reset");
        sb.delete();
        nextFree = 0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, a, b, c);
    endtask

    // Monitor: busy is checked against the model every cycle; results on each valid rise.
    logic              prevValid = 1'b0;
    logic [2*WIDTH-1:0] lastP = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            automatic logic expBusy = 1'b0;
            exp_t e;
            foreach (sb[i]) begin
                if (sb[i].edgeNo <= cyc && cyc < sb[i].edgeNo + WIDTH) expBusy = 1'b1;
            end
            checkOutput("busy", 64'(bus.busy), 64'(expBusy));
            if (bus.valid && !prevValid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 64'd0, 64'd1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("p", 64'(bus.p), e.p);
                    checkOutput("ovf", 64'(bus.ovf), 64'(e.ovf));
                    checkOutput("latency", 64'(cyc - e.edgeNo), 64'(WIDTH));
                end
            end else if (bus.valid && prevValid) begin
                checkOutput("p_hold", 64'(bus.p), 64'(lastP));
            end
        end
        prevValid = bus.valid;
        lastP = bus.p;
    end

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        #2 checkResetOutputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(4'd3, 4'd2, 4'd1, WIDTH + 4);
        applyStimulus(4'd3, 4'd5, 4'd0, WIDTH + 2);
        applyStimulus(4'd0, 4'd9, 4'd8, WIDTH + 2);
        applyStimulus(4'd15, 4'd15, 4'd15, WIDTH + 2);
        applyStimulus(4'd1, 4'd1, 4'd0, WIDTH + 2);
        applyStimulus(4'd2, 4'd0, 4'd0, WIDTH + 2);
        applyStimulus(4'd7, 4'd0, 4'd5, WIDTH + 2);

        // Second start two cycles into the calculation must be ignored.
        applyStimulus(4'd3, 4'd2, 4'd1, 1);
        applyStimulus(4'd15, 4'd15, 4'd15, WIDTH + 3);

        applyStimulus(4'd15, 4'd15, 4'd15, 1);
        doReset(4'd1, 4'd1, 4'd1);
        for (int i = 0; i < WIDTH + 3; i++) driveCycle(1'b0, 4'd0, 4'd0, 4'd0);

        // start held high: one result every WIDTH+1 cycles.
        for (int i = 0; i < 4 * (WIDTH + 1); i++) begin
            driveCycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        end

        for (int i = 0; i < 200; i++) begin
            driveCycle($urandom_range(0, 3) == 0, WIDTH'($urandom), WIDTH'($urandom),
                       WIDTH'($urandom));
        end

        for (int i = 0; i < 4 * WIDTH && sb.size() != 0; i++) begin
            driveCycle(1'b0, 4'd0, 4'd0, 4'd0);
        end
        driveCycle(1'b0, 4'd0, 4'd0, 4'd0);
        checkOutput("pending_results", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_add_int.md
Name: mul_add_int

Overview:
- Sequential unsigned multiply-add. Computes p = a*b + c over WIDTH cycles using radix-2 shift-add.
- It is the inverse companion of the div_int divider: feeding it quotient, divisor and remainder reconstructs the dividend (q*y + r == x). This lets the datapath self-check divider results.
- Uses the same start/busy/valid handshake as div_int, so the two blocks can share one sequencer.

Parameters:
- WIDTH, 4, operand width in bits for a, b and c. Legal values are 2 to 32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation. Sampled on the rising edge; accepted only when busy=0.
- a  input  WIDTH  multiplicand. For the divider check, the quotient.
- b  input  WIDTH  multiplier. For the divider check, the divisor.
- c  input  WIDTH  addend. For the divider check, the remainder.
- busy  output  1  calculation in progress.
- valid  output  1  p and ovf hold the result of the last accepted operation.
- ovf  output  1  result does not fit in WIDTH bits (p[2*WIDTH-1:WIDTH] != 0).
- p  output  2*WIDTH  result a*b + c.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, busy=0, valid=0, ovf=0, p=0; internal registers and iteration counter cleared. An operation in flight is abandoned and no result is produced. The first start is honoured on the first rising edge after rst_n deasserts.
- States:
  - IDLE: after reset. busy=0, valid=0.
  - CALC: busy=1, valid=0.
  - DONE: busy=0, valid=1; p and ovf are held.
- Accept: on a rising edge in IDLE or DONE with start=1:
  - latch mcand = {WIDTH'b0, a} (2*WIDTH bits), mplr = b, acc = {WIDTH'b0, c}, count = 0;
  - busy<=1, valid<=0;
  - p and ovf keep their old values but are not valid;
  - go to CALC.
- Start while busy (CALC) is ignored. Operands are not re-sampled and the operation continues undisturbed.
- CALC step, each rising edge:
  - if mplr[0], acc <= acc + mcand;
  - mcand <= mcand << 1; mplr <= mplr >> 1; count <= count + 1.
- Termination: the step with count == WIDTH-1 is the last. On that edge:
  - p <= final acc, including that step's add;
  - ovf <= |final_acc[2*WIDTH-1:WIDTH];
  - busy<=0, valid<=1; go to DONE.
- Latency: fixed at WIDTH cycles from the accepting edge to the edge that raises valid, whatever the operand values. There is no early exit on b==0 or a==0.
- Back-to-back: start=1 in DONE is accepted on that edge. valid drops the following cycle, and p holds the previous value until the new result lands.
- Arithmetic:
  - Unsigned only.
  - Maximum result (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, which fits in 2*WIDTH bits, so acc never wraps.
  - No divide-by-zero analogue: b=0 gives p=c.
- start held high continuously: a new operation is accepted every WIDTH+1 cycles. Each accept lands on the DONE edge, and valid is high for exactly one cycle per result.
- Inputs a, b and c may change freely after the accepting edge.

Test Plan (WIDTH=4, clk period 10 ns):
- Reset, then a=3, b=2, c=1, start pulsed one cycle. Required: busy high for 4 cycles; then valid=1, p=7, ovf=0. p stays 7 with valid=1 until the next start.
- a=3, b=5, c=0 (divider case 15/5) -> p=15, ovf=0. Then a=0, b=9, c=8 (case 8/9) -> p=8, ovf=0. The same 4-cycle latency is required despite a=0.
- a=15, b=15, c=15 -> p=240 (8'hF0), ovf=1. Then a=1, b=1, c=0 -> p=1, ovf=0, confirming ovf clears.
- b=0: a=2, b=0, c=0 -> p=0. Then a=7, b=0, c=5 -> p=5. No error flag is raised in either case.
- Start with a=3, b=2, c=1. Two cycles later, pulse start with a=15, b=15, c=15 while busy=1. Required: the second start is ignored and the result is p=7 at the original time.
- Start with a=15, b=15, c=15; assert rst_n=0 mid-CALC (cycle 2). Required: busy, valid, ovf and p all go to 0 immediately, without waiting for clk. After release, a=1, b=1, c=1 -> p=2, valid after 4 cycles.
